// File: rtl/cpu_defs.sv
// Shared definitions for the instruction-fetch path: FSM encodings, PC step and halt opcode.
package cpu_defs;
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FETCH  = 2'd1,
      ST_HALTED = 2'd2
   } fetch_state_t;

   localparam int          PC_STEP        = 4;
   localparam logic [31:0] HALT_INSTR_DEF = 32'hFFFF_FFFF;
endpackage

// File: rtl/fetch_out_reg.sv
// Decode-facing output register: load a fetched word, hold it under backpressure, or flush it.
module fetch_out_reg #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              flush,
   input  logic [DATA_W-1:0] d_instr,
   input  logic [ADDR_W-1:0] d_pc,
   output logic              instr_valid,
   output logic [DATA_W-1:0] instr_out,
   output logic [ADDR_W-1:0] instr_pc
);
   // flush only drops the valid flag; data is don't-care once invalid
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_valid <= 1'b0;
         instr_out   <= '0;
         instr_pc    <= '0;
      end else if (flush) begin
         instr_valid <= 1'b0;
      end else if (load) begin
         instr_valid <= 1'b1;
         instr_out   <= d_instr;
         instr_pc    <= d_pc;
      end
   end
endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, reads the ROM and issues words to decode.
//  state     | meaning
//  ST_IDLE   | one cycle after reset before the first ROM read
//  ST_FETCH  | reading ROM at fetch_pc, loading the output slot when free
//  ST_HALTED | halt word seen; waiting for a redirect to resume
module fetch_sequencer
   import cpu_defs::*;
#(
   parameter int                ADDR_W     = 32,
   parameter int                DATA_W     = 32,
   parameter logic [ADDR_W-1:0] RESET_PC   = '0,
   parameter logic [DATA_W-1:0] HALT_INSTR = DATA_W'(HALT_INSTR_DEF)
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [DATA_W-1:0] imem_data,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [DATA_W-1:0] instr_out,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              halt,
   output logic              misalign_err,
   output logic [31:0]       issued_count
);
   fetch_state_t      state, state_nxt;
   logic [ADDR_W-1:0] fetch_pc, fetch_pc_nxt;
   logic              halt_nxt;
   logic              slot_load, slot_flush;
   logic              slot_free, is_halt_word, redir_take, handshake;

   assign imem_addr    = fetch_pc;
   assign slot_free    = !instr_valid || instr_ready;
   assign is_halt_word = (imem_data == HALT_INSTR);
   assign redir_take   = redirect_valid && (state != ST_IDLE);
   assign handshake    = instr_valid && instr_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   state_nxt = ST_FETCH;
         ST_FETCH:  if (!redirect_valid && slot_free && is_halt_word) state_nxt = ST_HALTED;
         ST_HALTED: if (redirect_valid) state_nxt = ST_FETCH;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      slot_load    = 1'b0;
      slot_flush   = 1'b0;
      fetch_pc_nxt = fetch_pc;
      halt_nxt     = halt;
      if (redir_take) begin
         slot_flush   = 1'b1;
         fetch_pc_nxt = {redirect_pc[ADDR_W-1:2], 2'b00};
         halt_nxt     = 1'b0;
      end else if (state == ST_FETCH && slot_free) begin
         if (is_halt_word) begin
            slot_flush = 1'b1;
            halt_nxt   = 1'b1;
         end else begin
            slot_load    = 1'b1;
            fetch_pc_nxt = fetch_pc + ADDR_W'(PC_STEP);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc     <= RESET_PC;
         halt         <= 1'b0;
         misalign_err <= 1'b0;
         issued_count <= '0;
      end else begin
         fetch_pc     <= fetch_pc_nxt;
         halt         <= halt_nxt;
         misalign_err <= redir_take && (|redirect_pc[1:0]);
         if (handshake) issued_count <= issued_count + 32'd1;
      end
   end

   fetch_out_reg #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_out_reg (
      .clk         (clk),
      .rst_n       (rst_n),
      .load        (slot_load),
      .flush       (slot_flush),
      .d_instr     (imem_data),
      .d_pc        (fetch_pc),
      .instr_valid (instr_valid),
      .instr_out   (instr_out),
      .instr_pc    (instr_pc)
   );
endmodule
